// File: rtl/ad_volt_pkg.sv
// rtl/ad_volt_pkg.sv - shared types and constants for the AD9226 voltage sequencer
package ad_volt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_MAG   = 3'd2,
        ST_SCALE = 3'd3,
        ST_CONV  = 3'd4,
        ST_STORE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [7:0] ASCII_PLUS  = 8'd43;
    localparam logic [7:0] ASCII_MINUS = 8'd45;

    // 1 LSB = MV_FULL / 2^LSB_SHIFT millivolts
    localparam int MV_FULL   = 5000;
    localparam int LSB_SHIFT = 11;

    // one double-dabble iteration per binary input bit
    localparam int BCD_ITER  = 16;

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift
    function automatic logic [19:0] bcd_add3(input logic [19:0] d);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = (d[i*4 +: 4] >= 4'd5) ? d[i*4 +: 4] + 4'd3 : d[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_serial.sv
// rtl/bcd_serial.sv - serial 16-bit binary to 5-digit BCD converter, one bit per cycle
module bcd_serial
    import ad_volt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [19:0] dec,
    output logic        done
);

    localparam int CNT_W = $clog2(BCD_ITER);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BCD_ITER - 1);

    logic [15:0]      r_bin;
    logic [19:0]      r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic [19:0]      w_adj;
    logic             w_unused_msb;

    // inputs are at most 5000, so the top digit never carries out of bit 19
    assign w_adj        = bcd_add3(r_bcd);
    assign w_unused_msb = w_adj[19];

    // done is high during the cycle that performs the last iteration
    assign done = r_run && (r_cnt == LAST_ITER);
    assign dec  = r_bcd;

    // a start always (re)loads the converter, even mid-run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bcd <= {w_adj[18:0], r_bin[15]};
            r_bin <= {r_bin[14:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ad_volt_sched.sv
// rtl/ad_volt_sched.sv - sample tick, scheduled BCD conversion and atomic result update
module ad_volt_sched
    import ad_volt_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000
) (
    input  logic        ad_clk,
    input  logic        rst_n,
    input  logic [11:0] ad_ch1,
    input  logic [11:0] ad_ch2,
    input  logic        hold,
    input  logic        clr_missed,
    output logic [19:0] ch1_dec,
    output logic [19:0] ch2_dec,
    output logic [7:0]  ch1_sig,
    output logic [7:0]  ch2_sig,
    output logic        upd,
    output logic        busy,
    output logic        missed
);

    // a full two-channel set takes 40 cycles after the tick
    generate
        if (SAMPLE_DIV < 41) begin : g_bad_div
            $error("ad_volt_sched: SAMPLE_DIV must be at least 41");
        end
    endgenerate

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;

    logic [11:0] r_raw1;
    logic [11:0] r_raw2;
    logic        r_sel;
    logic [12:0] r_mag;
    logic [7:0]  r_sign;
    logic [19:0] r_sh1_dec;
    logic [19:0] r_sh2_dec;
    logic [7:0]  r_sh1_sig;
    logic [7:0]  r_sh2_sig;
    logic [19:0] r_ch1_dec;
    logic [19:0] r_ch2_dec;
    logic [7:0]  r_ch1_sig;
    logic [7:0]  r_ch2_sig;
    logic        r_missed;

    logic [11:0] w_raw;
    logic [12:0] w_mag;
    logic [24:0] w_prod;
    logic [15:0] w_mv;
    logic        w_start;
    logic [19:0] w_dec;
    logic        w_done;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // free-running sample divider, independent of hold and busy
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: ch1 then ch2 through MAG/SCALE/CONV/STORE, then publish
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_tick && !hold) w_state_next = ST_LATCH;
            ST_LATCH: w_state_next = ST_MAG;
            ST_MAG:   w_state_next = ST_SCALE;
            ST_SCALE: w_state_next = ST_CONV;
            ST_CONV:  if (w_done) w_state_next = ST_STORE;
            ST_STORE: w_state_next = r_sel ? ST_DONE : ST_MAG;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        busy    = 1'b0;
        upd     = 1'b0;
        w_start = 1'b0;
        if (r_state != ST_IDLE) busy = 1'b1;
        if (r_state == ST_DONE) upd = 1'b1;
        if (r_state == ST_SCALE) w_start = 1'b1;
    end

    // sign/magnitude of the selected channel; 0x800 yields 2048
    assign w_raw  = r_sel ? r_raw2 : r_raw1;
    assign w_mag  = w_raw[11] ? (13'd4096 - {1'b0, w_raw}) : {1'b0, w_raw};

    // mv = mag * 5000 / 2048, never above 5000
    assign w_prod = 25'(r_mag) * 25'(MV_FULL);
    assign w_mv   = 16'(w_prod >> LSB_SHIFT);

    bcd_serial u_bcd (
        .clk   (ad_clk),
        .rst_n (rst_n),
        .start (w_start),
        .bin   (w_mv),
        .dec   (w_dec),
        .done  (w_done)
    );

    // per-channel datapath: latch both codes together, then fill the shadow registers
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw1    <= '0;
            r_raw2    <= '0;
            r_sel     <= 1'b0;
            r_mag     <= '0;
            r_sign    <= ASCII_PLUS;
            r_sh1_dec <= '0;
            r_sh2_dec <= '0;
            r_sh1_sig <= ASCII_PLUS;
            r_sh2_sig <= ASCII_PLUS;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    r_raw1 <= ad_ch1;
                    r_raw2 <= ad_ch2;
                    r_sel  <= 1'b0;
                end
                ST_MAG: begin
                    r_mag  <= w_mag;
                    r_sign <= w_raw[11] ? ASCII_MINUS : ASCII_PLUS;
                end
                ST_STORE: begin
                    if (!r_sel) begin
                        r_sh1_dec <= w_dec;
                        r_sh1_sig <= r_sign;
                        r_sel     <= 1'b1;
                    end else begin
                        r_sh2_dec <= w_dec;
                        r_sh2_sig <= r_sign;
                    end
                end
                default: ;
            endcase
        end
    end

    // published results change only in DONE, so both channels update together
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch1_dec <= '0;
            r_ch2_dec <= '0;
            r_ch1_sig <= ASCII_PLUS;
            r_ch2_sig <= ASCII_PLUS;
        end else if (r_state == ST_DONE) begin
            r_ch1_dec <= r_sh1_dec;
            r_ch2_dec <= r_sh2_dec;
            r_ch1_sig <= r_sh1_sig;
            r_ch2_sig <= r_sh2_sig;
        end
    end

    // sticky overrun flag; a clear wins over a simultaneous set
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_missed <= 1'b0;
        end else if (clr_missed) begin
            r_missed <= 1'b0;
        end else if (w_tick && (r_state != ST_IDLE)) begin
            r_missed <= 1'b1;
        end
    end

    assign ch1_dec = r_ch1_dec;
    assign ch2_dec = r_ch2_dec;
    assign ch1_sig = r_ch1_sig;
    assign ch2_sig = r_ch2_sig;
    assign missed  = r_missed;

endmodule

// File: tb/tb_ad_volt_sched.sv
// tb/tb_ad_volt_sched.sv - self-checking bench for ad_volt_sched
module tb_ad_volt_sched;

    logic        ad_clk = 1'b0;
    logic        rst_n;
    logic [11:0] ad_ch1;
    logic [11:0] ad_ch2;
    logic        hold;
    logic        clr_missed;
    logic [19:0] ch1_dec;
    logic [19:0] ch2_dec;
    logic [7:0]  ch1_sig;
    logic [7:0]  ch2_sig;
    logic        upd;
    logic        busy;
    logic        missed;

    int checks   = 0;
    int failures = 0;

    ad_volt_sched #(.SAMPLE_DIV(64)) dut (
        .ad_clk     (ad_clk),
        .rst_n      (rst_n),
        .ad_ch1     (ad_ch1),
        .ad_ch2     (ad_ch2),
        .hold       (hold),
        .clr_missed (clr_missed),
        .ch1_dec    (ch1_dec),
        .ch2_dec    (ch2_dec),
        .ch1_sig    (ch1_sig),
        .ch2_sig    (ch2_sig),
        .upd        (upd),
        .busy       (busy),
        .missed     (missed)
    );

    always #5 ad_clk = ~ad_clk;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [19:0] d1;
        logic [7:0]  s1;
        logic [19:0] d2;
        logic [7:0]  s2;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference: signed code -> |volts| in mV (floor) as decimal digits, plus sign char
    function automatic logic [27:0] model(input logic [11:0] code);
        int v;
        int mv;
        logic [19:0] d;
        v  = code[11] ? int'(code) - 4096 : int'(code);
        mv = ((v < 0) ? -v : v) * 5000 / 2048;
        d  = '0;
        for (int i = 0; i < 5; i++) begin
            d[i*4 +: 4] = 4'(mv % 10);
            mv = mv / 10;
        end
        return {((v < 0) ? 8'd45 : 8'd43), d};
    endfunction

    // waits for the next sample set and checks timing, stability and results
    task automatic run_set(input logic [11:0] a, input logic [11:0] b,
                           input logic [19:0] d1, input logic [7:0] s1,
                           input logic [19:0] d2, input logic [7:0] s2,
                           input bit scramble, input int inject, input string tag);
        int  n;
        bit  seen;
        bit  spurious;
        bit  stable;
        bit  busy_ok;
        logic [55:0] snap;
        ad_ch1   = a;
        ad_ch2   = b;
        seen     = 0;
        spurious = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge ad_clk);
            if (upd) spurious = 1;
            if (busy) seen = 1;
        end
        chk({tag, "_busy_rise"}, 32'(seen), 32'd1);
        chk({tag, "_idle_upd"}, 32'(spurious), 32'd0);
        if (!seen) return;
        snap    = {ch1_dec, ch1_sig, ch2_dec, ch2_sig};
        stable  = 1;
        busy_ok = 1;
        seen    = 0;
        n       = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge ad_clk);
            n++;
            if (scramble) begin
                ad_ch1 = 12'($urandom);
                ad_ch2 = 12'($urandom);
            end
            if (n == inject) force dut.w_tick = 1'b1;
            if (n == inject + 1) begin
                release dut.w_tick;
                chk({tag, "_missed_set"}, 32'(missed), 32'd1);
            end
            if ({ch1_dec, ch1_sig, ch2_dec, ch2_sig} !== snap) stable = 0;
            if (!busy) busy_ok = 0;
            if (upd) seen = 1;
        end
        chk({tag, "_upd_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd39);
        chk({tag, "_stable"}, 32'(stable), 32'd1);
        chk({tag, "_busy_span"}, 32'(busy_ok), 32'd1);
        @(negedge ad_clk);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_upd_end"}, 32'(upd), 32'd0);
        chk({tag, "_ch1_dec"}, 32'(ch1_dec), 32'(d1));
        chk({tag, "_ch1_sig"}, 32'(ch1_sig), 32'(s1));
        chk({tag, "_ch2_dec"}, 32'(ch2_dec), 32'(d2));
        chk({tag, "_ch2_sig"}, 32'(ch2_sig), 32'(s2));
    endtask

    task automatic run_rand(input bit scramble, input int inject, input string tag);
        logic [11:0] a;
        logic [11:0] b;
        logic [27:0] m1;
        logic [27:0] m2;
        a  = 12'($urandom);
        b  = 12'($urandom);
        m1 = model(a);
        m2 = model(b);
        run_set(a, b, m1[19:0], m1[27:20], m2[19:0], m2[27:20], scramble, inject, tag);
    endtask

    initial begin
        bit bad_busy;
        bit bad_upd;
        bit moved;
        logic [55:0] snap;

        vecs[0] = '{a: 12'h400, b: 12'hC00, d1: 20'h02500, s1: 8'd43, d2: 20'h02500, s2: 8'd45};
        vecs[1] = '{a: 12'h7FF, b: 12'h800, d1: 20'h04997, s1: 8'd43, d2: 20'h05000, s2: 8'd45};
        vecs[2] = '{a: 12'h000, b: 12'hFFF, d1: 20'h00000, s1: 8'd43, d2: 20'h00002, s2: 8'd45};

        rst_n      = 1'b0;
        hold       = 1'b0;
        clr_missed = 1'b0;
        ad_ch1     = '0;
        ad_ch2     = '0;
        @(negedge ad_clk);
        @(negedge ad_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_missed", 32'(missed), 32'd0);
        chk("rst_ch1_dec", 32'(ch1_dec), 32'd0);
        chk("rst_ch2_dec", 32'(ch2_dec), 32'd0);
        chk("rst_ch1_sig", 32'(ch1_sig), 32'd43);
        chk("rst_ch2_sig", 32'(ch2_sig), 32'd43);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run_set(vecs[i].a, vecs[i].b, vecs[i].d1, vecs[i].s1, vecs[i].d2, vecs[i].s2,
                    1'b0, -10, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            run_rand(i[0], -10, $sformatf("rnd%0d", i));
        end
        chk("no_missed_normal", 32'(missed), 32'd0);

        // hold across two full tick periods: nothing may start or change
        snap     = {ch1_dec, ch1_sig, ch2_dec, ch2_sig};
        bad_busy = 0;
        bad_upd  = 0;
        moved    = 0;
        hold     = 1'b1;
        ad_ch1   = 12'h123;
        ad_ch2   = 12'h987;
        for (int i = 0; i < 140; i++) begin
            @(negedge ad_clk);
            if (busy) bad_busy = 1;
            if (upd) bad_upd = 1;
            if ({ch1_dec, ch1_sig, ch2_dec, ch2_sig} !== snap) moved = 1;
        end
        hold = 1'b0;
        chk("hold_busy", 32'(bad_busy), 32'd0);
        chk("hold_upd", 32'(bad_upd), 32'd0);
        chk("hold_outputs", 32'(moved), 32'd0);

        // a tick forced mid-conversion flags missed and is otherwise dropped
        run_rand(1'b0, 10, "inject");
        chk("missed_sticky", 32'(missed), 32'd1);
        clr_missed = 1'b1;
        @(negedge ad_clk);
        clr_missed = 1'b0;
        chk("missed_clear", 32'(missed), 32'd0);

        // asynchronous reset in the middle of a conversion
        bad_busy = 0;
        for (int i = 0; i < 200 && !bad_busy; i++) begin
            @(negedge ad_clk);
            if (busy) bad_busy = 1;
        end
        chk("abort_busy_rise", 32'(bad_busy), 32'd1);
        repeat (23) @(negedge ad_clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_upd", 32'(upd), 32'd0);
        chk("abort_ch1_dec", 32'(ch1_dec), 32'd0);
        chk("abort_ch2_dec", 32'(ch2_dec), 32'd0);
        chk("abort_ch1_sig", 32'(ch1_sig), 32'd43);
        chk("abort_ch2_sig", 32'(ch2_sig), 32'd43);
        @(negedge ad_clk);
        @(negedge ad_clk);
        rst_n = 1'b1;
        run_set(vecs[0].a, vecs[0].b, vecs[0].d1, vecs[0].s1, vecs[0].d2, vecs[0].s2,
                1'b1, -10, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad_volt_sched.md
# ad_volt_sched

Sequencer for the AD9226 dual-channel voltage path. It samples both 12-bit ADC channels on a programmable tick and converts each to sign plus millivolts (1 LSB = 5000/2048 mV). It then time-shares one serial binary-to-BCD converter between the two channels, round-robin, and publishes both 5-digit BCD results atomically to the display/UART formatting logic. It replaces a free-running per-channel converter pair with one scheduled converter and a clean update strobe.

## Interface
Parameters:
- SAMPLE_DIV, 50000: ad_clk cycles between sample ticks. Must be ≥ 41; smaller values are an elaboration error.

Ports:
- ad_clk  in  1  sole clock for the block.
- rst_n  in  1  reset, asynchronous and active-low.
- ad_ch1  in  12  channel 1 ADC code, two's complement.
- ad_ch2  in  12  channel 2 ADC code, two's complement.
- hold  in  1  while high, sample ticks are not acted on; outputs freeze.
- clr_missed  in  1  synchronous clear of `missed`.
- ch1_dec  out  20  channel 1 magnitude in mV, 5 BCD digits.
- ch2_dec  out  20  channel 2 magnitude in mV, 5 BCD digits.
- ch1_sig  out  8  channel 1 sign character: ASCII 45 '-' or 43 '+'.
- ch2_sig  out  8  channel 2 sign character: ASCII 45 '-' or 43 '+'.
- upd  out  1  one-cycle pulse when all four result outputs change.
- busy  out  1  high whenever the FSM is not in IDLE.
- missed  out  1  sticky flag: a tick arrived while busy.

## Operation
- Tick counter runs 0..SAMPLE_DIV-1 and wraps. `tick` is asserted when the count equals SAMPLE_DIV-1. The counter runs regardless of `hold` and `busy`.
- FSM states: IDLE, LATCH, MAG, SCALE, CONV, STORE, DONE. A channel pointer `sel` (0 = ch1, 1 = ch2) selects the channel being processed.
- IDLE → LATCH on `tick` and `!hold`. A tick with `hold` high is silently ignored.
- LATCH: register both ad_ch1 and ad_ch2 in the same cycle; set sel = 0. → MAG.
- MAG: if raw[11] is set, mag = 13'd4096 − raw and sign = 45; otherwise mag = raw and sign = 43. Code 0x800 gives mag = 2048. → SCALE.
- SCALE: mv = (mag × 5000) >> 11, computed in 25 bits then truncated. mv ≤ 5000. Start the BCD converter with the 16-bit zero-extended mv. → CONV.
- CONV: serial double-dabble, exactly 16 iterations at one per cycle. In each iteration, add 3 to every BCD nibble ≥ 5, then shift left, bringing in the next binary MSB. → STORE when the converter's `done` is asserted.
- STORE: write the BCD result and sign into the shadow registers for `sel`.
  - If sel = 0: set sel = 1, → MAG.
  - If sel = 1: → DONE.
- DONE: copy both shadow channels to ch*_dec and ch*_sig, pulse `upd`. → IDLE.
- Outputs change only in DONE. A half-finished sample set is never visible.
- `tick` in any state other than IDLE sets `missed`. `clr_missed` has priority over a simultaneous set. The tick itself is dropped, not queued.
- `hold` asserted mid-conversion has no effect; the current set completes and `upd` fires.
- `rst_n` low mid-operation aborts immediately. All state returns to reset values and no `upd` is produced.
- Reset values:
  - ch*_dec = 0 and ch*_sig = 43.
  - upd = 0, busy = 0, missed = 0.
  - Tick counter = 0; FSM = IDLE.

## Timing
- Tick seen in IDLE at cycle 0: LATCH is cycle 1.
- ch1: MAG at 2, SCALE at 3, CONV at 4–19, STORE at 20.
- ch2: MAG at 21, SCALE at 22, CONV at 23–38, STORE at 39.
- DONE and `upd` high at cycle 40; outputs are valid from cycle 41.
- `busy` is high from cycle 1 through 40 inclusive.
- With SAMPLE_DIV ≥ 41, `missed` never sets in normal operation.
- ADC inputs are sampled only in LATCH. Input changes at any other time are ignored.

## Structure
- Package `ad_volt_pkg` holds:
  - the state enum;
  - ASCII_PLUS = 43 and ASCII_MINUS = 45;
  - MV_FULL = 5000 and LSB_SHIFT = 11;
  - BCD_ITER = 16.
- Sub-module `bcd_serial` has:
  - inputs: clk, rst_n, start, bin[15:0];
  - outputs: dec[19:0], done.
  - `done` is a one-cycle pulse 16 cycles after `start`.
  - A `start` while the converter is running restarts it.
- The top level holds the tick counter, the FSM, the MAG/SCALE datapath, the shadow registers and the output registers.

## Test plan
- ad_ch1 = 0x400, ad_ch2 = 0xC00, SAMPLE_DIV = 64 → upd 40 cycles after the tick; ch1 = 0x02500/43, ch2 = 0x02500/45.
- ad_ch1 = 0x7FF, ad_ch2 = 0x800 → ch1 = 0x04997/43, ch2 = 0x05000/45.
- ad_ch1 = 0x000, ad_ch2 = 0xFFF → ch1 = 0x00000/43, ch2 = 0x00002/45.
- Inputs change every cycle during cycles 2–39 → results reflect only the codes present at LATCH; outputs stay stable until cycle 40.
- hold = 1 across a tick → no busy, no upd, outputs unchanged. Force an internal tick while busy → missed = 1; clr_missed → 0.
- rst_n pulsed low at cycle 25 of a conversion → all outputs at reset values, no upd. The next tick produces a full 40-cycle sequence.
